// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word addresses to a one-cycle-latency instruction
// memory, queues the returned words and hands them to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_SIZE  = 1024,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_addr,
  input  logic [31:0] mem_instruction,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_fault
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0] fetchPc_q, fetchPc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflightPc_q, inflightPc_d;
  logic        inflightFault_q, inflightFault_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;

  logic [31:0] bufInstr_q [BUF_DEPTH];
  logic [31:0] bufPc_q    [BUF_DEPTH];
  logic        bufFault_q [BUF_DEPTH];

  logic        headValid;
  logic        pop;
  logic        push;
  logic        issue;
  logic [CNT_W:0] occupancy;

  function automatic ptr_t nextPtr(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign headValid  = (count_q != '0);
  assign dec_valid  = headValid & ~redirect_valid;
  assign dec_instr  = headValid ? bufInstr_q[head_q] : '0;
  assign dec_pc     = headValid ? bufPc_q[head_q]    : '0;
  assign dec_fault  = headValid ? bufFault_q[head_q] : 1'b0;
  assign fetch_addr = fetchPc_q;

  assign pop  = dec_valid & dec_ready;
  assign push = inflight_q & ~redirect_valid;

  // Credit check counts the word already in flight so the queue can never overflow.
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue     = fetch_enable & ~redirect_valid &
                     (occupancy < (CNT_W + 1)'(BUF_DEPTH));

  always_comb begin
    fetchPc_d       = fetchPc_q;
    inflight_d      = 1'b0;
    inflightPc_d    = inflightPc_q;
    inflightFault_d = inflightFault_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    if (redirect_valid) begin
      fetchPc_d = redirect_pc;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (issue) begin
        inflight_d      = 1'b1;
        inflightPc_d    = fetchPc_q;
        inflightFault_d = (fetchPc_q >= 32'(MEM_SIZE));
        fetchPc_d       = fetchPc_q + 32'd1;
      end
      if (pop) begin
        head_d = nextPtr(head_q);
      end
      if (push) begin
        tail_d = nextPtr(tail_q);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q       <= RESET_PC;
      inflight_q      <= 1'b0;
      inflightPc_q    <= '0;
      inflightFault_q <= 1'b0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
    end else begin
      fetchPc_q       <= fetchPc_d;
      inflight_q      <= inflight_d;
      inflightPc_q    <= inflightPc_d;
      inflightFault_q <= inflightFault_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      bufInstr_q[tail_q] <= mem_instruction;
      bufPc_q[tail_q]    <= inflightPc_q;
      bufFault_q[tail_q] <= inflightFault_q;
    end
  end

  noPushIntoFullQueue: assert property (@(posedge clk) disable iff (reset)
    push |-> ((count_q != cnt_t'(BUF_DEPTH)) || pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written redirect and
// reset sequences, then random traffic checked every cycle against a queue-based model.
module tb_instruction_fetch_unit;

  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetchEnable = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;
  logic [31:0] fetchAddr;
  logic [31:0] memInstruction = '0;
  logic        decValid;
  logic        decReady = 1'b0;
  logic [31:0] decInstr;
  logic [31:0] decPc;
  logic        decFault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (32'h0),
    .MEM_SIZE (MEM_SIZE),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetchEnable),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .fetch_addr     (fetchAddr),
    .mem_instruction(memInstruction),
    .dec_valid      (decValid),
    .dec_ready      (decReady),
    .dec_instr      (decInstr),
    .dec_pc         (decPc),
    .dec_fault      (decFault)
  );

  // Contents of instruction memory; out-of-range reads return a poison word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a < MEM_SIZE) ? (32'hA500_0000 ^ (a * 32'h0001_0193)) : 32'hDEADBEEF;
  endfunction

  // Registered memory: the word for this cycle's address appears next cycle.
  always @(posedge clk) memInstruction <= memWord(fetchAddr);

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds delivered words, pend holds the word whose
  // address went out last cycle; instruction values come from memWord directly.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  entry_t      mQ[$];
  entry_t      mPend[$];
  entry_t      mEnt;
  logic [31:0] mPc = 32'h0;
  bit          mPop;
  bit          mIssue;
  int          mOcc;

  always @(posedge clk) begin
    if (reset) begin
      mQ.delete();
      mPend.delete();
      mPc = 32'h0;
    end else if (redirectValid) begin
      mQ.delete();
      mPend.delete();
      mPc = redirectPc;
    end else begin
      mPop   = (mQ.size() > 0) && decReady;
      mOcc   = mQ.size() + mPend.size() - (mPop ? 1 : 0);
      mIssue = fetchEnable && (mOcc < int'(DEPTH));
      if (mPop) void'(mQ.pop_front());
      if (mPend.size() > 0) begin
        mEnt = mPend.pop_front();
        mEnt.instr = memWord(mEnt.pc);
        mQ.push_back(mEnt);
      end
      if (mIssue) begin
        mEnt.pc    = mPc;
        mEnt.instr = 32'h0;
        mEnt.fault = (mPc >= MEM_SIZE);
        mPend.push_back(mEnt);
        mPc = mPc + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    checkValue("model dec_valid", 32'(decValid), 32'((mQ.size() > 0) && !redirectValid));
    checkValue("model fetch_addr", fetchAddr, mPc);
    if ((mQ.size() > 0) && !redirectValid) begin
      checkValue("model dec_pc", decPc, mQ[0].pc);
      checkValue("model dec_instr", decInstr, mQ[0].instr);
      checkValue("model dec_fault", 32'(decFault), 32'(mQ[0].fault));
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset         = rst;
    fetchEnable   = en;
    redirectValid = rv;
    redirectPc    = rpc;
    decReady      = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic expValid,
                             input logic [31:0] expPc, input logic [31:0] expAddr,
                             input logic zeroPayload);
    checkValue({name, " dec_valid"}, 32'(decValid), 32'(expValid));
    checkValue({name, " fetch_addr"}, fetchAddr, expAddr);
    if (expValid) begin
      checkValue({name, " dec_pc"}, decPc, expPc);
      checkValue({name, " dec_instr"}, decInstr, memWord(expPc));
      checkValue({name, " dec_fault"}, 32'(decFault), 32'(expPc >= MEM_SIZE));
    end else if (zeroPayload) begin
      checkValue({name, " dec_pc zero"}, decPc, 32'h0);
      checkValue({name, " dec_instr zero"}, decInstr, 32'h0);
      checkValue({name, " dec_fault zero"}, 32'(decFault), 32'h0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expAddr;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rst, input logic en, input logic rdy,
                                 input logic expValid, input logic [31:0] expPc,
                                 input logic [31:0] expAddr, input logic zero);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy;
    v.expValid = expValid; v.expPc = expPc; v.expAddr = expAddr; v.zero = zero;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] rpc;
    // Reset, then streaming from PC 0 with decode always ready.
    addVec(1, 1, 1, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 0, 1);
    addVec(0, 1, 1, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 0, 1, 0);
    addVec(0, 1, 1, 1, 0, 2, 0);
    addVec(0, 1, 1, 1, 1, 3, 0);
    addVec(0, 1, 1, 1, 2, 4, 0);
    addVec(0, 1, 1, 1, 3, 5, 0);
    // Reset mid-stream, then a five-cycle decode stall on the first valid word.
    addVec(1, 1, 1, 1, 4, 6, 0);
    addVec(0, 1, 1, 0, 0, 0, 1);
    addVec(0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) addVec(0, 1, 0, 1, 0, 2, 0);
    addVec(0, 1, 1, 1, 0, 2, 0);
    addVec(0, 1, 1, 1, 1, 3, 0);
    addVec(0, 1, 1, 1, 2, 4, 0);
    addVec(0, 1, 1, 1, 3, 5, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, 1'b0, 32'h0, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                  vecs[i].expAddr, vecs[i].zero);
    end

    // Redirect to 5, then redirect to 0x40 while word 5 is at the head with ready=1.
    applyStimulus(0, 1, 1, 32'd5, 1);  checkOutput("redir5 cycle", 0, 0, 6, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir5 +1", 0, 0, 5, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir5 +2", 0, 0, 6, 0);
    applyStimulus(0, 1, 1, 32'h40, 1); checkOutput("redir40 cycle", 0, 0, 7, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir40 +1", 0, 0, 32'h40, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir40 +2", 0, 0, 32'h41, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir40 +3", 1, 32'h40, 32'h42, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);  checkOutput("redir40 +4", 1, 32'h41, 32'h43, 0);

    // Crossing the end of memory: last good word, then a faulting fetch.
    applyStimulus(0, 1, 1, 32'd1023, 1); checkOutput("redir1023 cycle", 0, 0, 32'h44, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("redir1023 +1", 0, 0, 1023, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("redir1023 +2", 0, 0, 1024, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("edge pc1023", 1, 1023, 1025, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("fault pc1024", 1, 1024, 1026, 0);

    // Fill the queue, reset, then redirect to the top of the address space.
    applyStimulus(0, 1, 0, 32'd0, 0);    checkOutput("fill 1", 1, 1025, 1027, 0);
    applyStimulus(0, 1, 0, 32'd0, 0);    checkOutput("fill 2", 1, 1025, 1027, 0);
    applyStimulus(1, 1, 0, 32'd0, 0);    checkOutput("reset full", 1, 1025, 1027, 0);
    applyStimulus(0, 0, 0, 32'd0, 1);    checkOutput("after reset", 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'hFFFFFFFF, 1); checkOutput("redirTop cycle", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("redirTop +1", 0, 0, 32'hFFFFFFFF, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("redirTop +2", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("top pc", 1, 32'hFFFFFFFF, 1, 0);
    applyStimulus(0, 1, 0, 32'd0, 1);    checkOutput("wrap pc0", 1, 0, 2, 0);

    // Random traffic; the model comparison runs on every cycle.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFFFFFF - $urandom_range(0, 3);
        1:       rpc = $urandom_range(1015, 1030);
        default: rpc = $urandom_range(0, 2000);
      endcase
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
